mem_access_unit: RTL and testbench

//  Byte-addressed 512x8 main memory with MFA/MFC handshake. Sits directly downstream of the

---
 rtl/mem_access_unit_pkg.sv | 34 +++
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit_byte_array.sv | 42 ++++
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Shared encodings for the byte-addressed memory access unit.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    localparam int MEM_DEPTH = 512;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 2'b11 is an alias for a word access
    function automatic logic [2:0] lane_count(input logic [1:0] size);
        case (size)
            SIZE_BYTE: lane_count = 3'd1;
            SIZE_HALF: lane_count = 3'd2;
            default:   lane_count = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : MFA/MFC request/complete bus between control unit and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 9
);
    logic              MFA;
    logic              RW;
    logic [ADDR_W-1:0] address;
    logic [31:0]       dataIn;
    logic [1:0]        dataSize;
    logic [31:0]       dataOut;
    logic              MFC;
    logic              addrError;

    modport master (
        output MFA, RW, address, dataIn, dataSize,
        input  dataOut, MFC, addrError
    );

    modport slave (
        input  MFA, RW, address, dataIn, dataSize,
        output dataOut, MFC, addrError
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_byte_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_array
// Purpose  : DEPTH x 8 storage with four consecutive-byte lanes (modulo DEPTH)
//            for reading and byte-enabled writing. Contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
module mem_byte_array #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     base,
    input  logic [3:0]            we,
    input  logic [3:0][7:0]       wdata,
    output logic [3:0][7:0]       rdata
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem  [DEPTH];
    logic [ADDR_W-1:0] w_addr [4];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [ADDR_W:0] w_sum;
        assign w_sum    = {1'b0, base} + (ADDR_W+1)'(k);
        // Lanes that run past the top of memory wrap back to address 0
        assign w_addr[k] = (w_sum >= c_DEPTH) ? ADDR_W'(w_sum - c_DEPTH)
                                              : ADDR_W'(w_sum);
        assign rdata[k]  = r_mem[w_addr[k]];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                r_mem[w_addr[k]] <= wdata[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Big-endian byte-addressed memory behind an MFA/MFC handshake.
//            Optional alignment check enabled by defining MEM_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DEPTH   = MEM_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int LATENCY = 2
) (
    input  logic                Clk,
    input  logic                reset,
    mem_access_unit_if.slave    bus
);

    localparam logic [3:0] c_LAT = 4'(LATENCY);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_mfc, w_mfc_nxt;
    logic [31:0]       r_dout, w_dout_nxt;
    logic              r_err, w_err_nxt;
    logic              w_capture;
    logic              w_access;

    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;

    logic              w_misaligned;
    logic [2:0]        w_lanes;
    logic [3:0]        w_lane_en;
    logic [3:0]        w_we;
    logic [3:0][7:0]   w_wbyte;
    logic [3:0][7:0]   w_rbyte;
    logic [31:0]       w_rdata;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = ((r_size == SIZE_HALF) && r_addr[0]) ||
                          (r_size[1] && (r_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_lanes = lane_count(r_size);

    // Lane 0 is the lowest address and carries the most significant byte
    always_comb begin
        w_lane_en = '0;
        w_wbyte   = '0;
        w_rdata   = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(w_lanes)) begin
                w_lane_en[k] = 1'b1;
                w_wbyte[k]   = r_wdata[8*(int'(w_lanes)-1-k) +: 8];
                w_rdata      = {w_rdata[23:0], w_rbyte[k]};
            end
        end
    end

    assign w_we = (w_access && (r_rw == RW_WRITE) && !w_misaligned) ? w_lane_en : 4'b0000;

    mem_byte_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (Clk),
        .base   (r_addr),
        .we     (w_we),
        .wdata  (w_wbyte),
        .rdata  (w_rbyte)
    );

    // Capture always passes through WAIT so MFC lands LATENCY+1 edges after capture
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mfc_nxt   = r_mfc;
        w_dout_nxt  = r_dout;
        w_err_nxt   = r_err;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.MFA) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = c_LAT;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.MFA) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_mfc_nxt   = 1'b1;
                    w_err_nxt   = w_misaligned;
                    w_dout_nxt  = ((r_rw == RW_READ) && !w_misaligned) ? w_rdata : 32'd0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                if (!bus.MFA) begin
                    w_mfc_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_mfc   <= 1'b0;
            r_dout  <= 32'd0;
            r_err   <= 1'b0;
            r_rw    <= RW_READ;
            r_addr  <= '0;
            r_size  <= SIZE_BYTE;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mfc   <= w_mfc_nxt;
            r_dout  <= w_dout_nxt;
            r_err   <= w_err_nxt;
            if (w_capture) begin
                r_rw    <= bus.RW;
                r_addr  <= bus.address;
                r_size  <= bus.dataSize;
                r_wdata <= bus.dataIn;
            end
        end
    end

    assign bus.MFC       = r_mfc;
    assign bus.dataOut   = r_dout;
    assign bus.addrError = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed and random checks of mem_access_unit against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 512;

    logic Clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] mm [DEPTH];

    mem_access_unit_if #(.ADDR_W(9)) bus_if();

    mem_access_unit #(
        .DEPTH   (DEPTH),
        .ADDR_W  (9),
        .LATENCY (LAT)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic rw, input logic [8:0] a, input logic [1:0] sz,
                                  input logic [31:0] d, output logic [31:0] dout, output logic err);
        int n;
        int idx;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        err  = 1'b0;
        dout = 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
        if ((n == 2 && (int'(a) % 2) != 0) || (n == 4 && (int'(a) % 4) != 0)) err = 1'b1;
`endif
        if (err) return;
        for (int k = 0; k < n; k++) begin
            idx = (int'(a) + k) % DEPTH;
            if (rw) dout = (dout << 8) | 32'(mm[idx]);
            else    mm[idx] = 8'(d >> (8 * (n - 1 - k)));
        end
    endfunction

    task automatic xact(input logic rw, input logic [8:0] a, input logic [1:0] sz,
                        input logic [31:0] d, output logic [31:0] dout, output logic err);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        model(rw, a, sz, d, exp_d, exp_e);
        @(negedge Clk);
        bus_if.MFA = 1'b1; bus_if.RW = rw; bus_if.address = a;
        bus_if.dataSize = sz; bus_if.dataIn = d;
        @(posedge Clk); #1;
        n = 1;
        // inputs after capture must have no effect on the access
        bus_if.RW = ~rw; bus_if.address = 9'($urandom);
        bus_if.dataIn = $urandom; bus_if.dataSize = 2'($urandom);
        while (bus_if.MFC !== 1'b1 && n < 40) begin
            @(posedge Clk); #1;
            n++;
        end
        check("mfc_latency", 32'(n), 32'(LAT + 2));
        check("dataOut", bus_if.dataOut, exp_d);
        check("addrError", 32'(bus_if.addrError), 32'(exp_e));
        dout = bus_if.dataOut;
        err  = bus_if.addrError;
        @(posedge Clk); #1;
        check("mfc_held", 32'(bus_if.MFC), 32'd1);
        check("dataOut_held", bus_if.dataOut, exp_d);
        @(negedge Clk);
        bus_if.MFA = 1'b0;
        @(posedge Clk); #1;
        check("mfc_drop", 32'(bus_if.MFC), 32'd0);
        check("addrError_drop", 32'(bus_if.addrError), 32'd0);
        check("dataOut_after_drop", bus_if.dataOut, exp_d);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        bus_if.MFA = 1'b0; bus_if.RW = RW_READ; bus_if.address = '0;
        bus_if.dataIn = '0; bus_if.dataSize = SIZE_BYTE;
        reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_mfc", 32'(bus_if.MFC), 32'd0);
        check("reset_dataOut", bus_if.dataOut, 32'd0);
        check("reset_addrError", 32'(bus_if.addrError), 32'd0);
        @(negedge Clk);
        reset = 1'b0;

        // preload every byte so later reads compare against known contents
        for (int i = 0; i < DEPTH / 4; i++) begin
            xact(RW_WRITE, 9'(i * 4), SIZE_WORD, $urandom, rd, er);
        end

        xact(RW_WRITE, 9'h004, SIZE_WORD, 32'hDEADBEEF, rd, er);
        xact(RW_READ,  9'h004, SIZE_WORD, 32'h0, rd, er);
        check("t1_word", rd, 32'hDEADBEEF);

        xact(RW_READ, 9'h005, SIZE_BYTE, 32'h0, rd, er);
        check("t2_byte", rd, 32'h000000AD);
        xact(RW_READ, 9'h006, SIZE_HALF, 32'h0, rd, er);
        check("t2_half", rd, 32'h0000BEEF);

        xact(RW_WRITE, 9'h007, SIZE_BYTE, 32'hFFFFFF5A, rd, er);
        xact(RW_READ,  9'h004, SIZE_WORD, 32'h0, rd, er);
        check("t3_word", rd, 32'hDEADBE5A);

`ifndef MEM_ALIGN_CHECK_EN
        xact(RW_WRITE, 9'h1FE, SIZE_WORD, 32'h11223344, rd, er);
        xact(RW_READ,  9'h1FE, SIZE_BYTE, 32'h0, rd, er);
        check("t4_byte_1fe", rd, 32'h00000011);
        xact(RW_READ,  9'h000, SIZE_BYTE, 32'h0, rd, er);
        check("t4_byte_000", rd, 32'h00000033);
        xact(RW_READ,  9'h1FF, SIZE_WORD, 32'h0, rd, er);
`endif

        // abort in WAIT by dropping MFA, then reset mid-WAIT on a second write
        xact(RW_READ, 9'h004, SIZE_WORD, 32'h0, rd, er);
        @(negedge Clk);
        bus_if.MFA = 1'b1; bus_if.RW = RW_WRITE; bus_if.address = 9'h010;
        bus_if.dataSize = SIZE_WORD; bus_if.dataIn = 32'hCAFEF00D;
        @(negedge Clk);
        bus_if.MFA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            check("t5_abort_mfc", 32'(bus_if.MFC), 32'd0);
        end
        check("t5_dataOut_kept", bus_if.dataOut, 32'hDEADBE5A);
        @(negedge Clk);
        bus_if.MFA = 1'b1; bus_if.address = 9'h014; bus_if.dataIn = 32'h0BADF00D;
        @(posedge Clk); #2;
        reset = 1'b1;
        bus_if.MFA = 1'b0;
        #1;
        check("t5_reset_mfc", 32'(bus_if.MFC), 32'd0);
        check("t5_reset_dataOut", bus_if.dataOut, 32'd0);
        check("t5_reset_addrError", 32'(bus_if.addrError), 32'd0);
        @(negedge Clk);
        reset = 1'b0;
        xact(RW_READ, 9'h010, SIZE_WORD, 32'h0, rd, er);
        xact(RW_READ, 9'h014, SIZE_WORD, 32'h0, rd, er);

`ifdef MEM_ALIGN_CHECK_EN
        xact(RW_WRITE, 9'h002, SIZE_WORD, 32'h12345678, rd, er);
        check("t6_addrError", 32'(er), 32'd1);
        check("t6_dataOut", rd, 32'd0);
        xact(RW_READ, 9'h000, SIZE_WORD, 32'h0, rd, er);
        xact(RW_READ, 9'h004, SIZE_WORD, 32'h0, rd, er);
        check("t6_unchanged", rd, 32'hDEADBE5A);
`endif

        for (int i = 0; i < 80; i++) begin
            xact(1'($urandom), 9'($urandom), 2'($urandom), $urandom, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
